// File: rtl/cn0363_dma_desequencer.sv
// rtl/cn0363_dma_desequencer.sv - scatters interleaved DMA read words to per-channel valid/ready streams.
// Optional CN0363_DESEQ_SYNC_CHECK_EN: checks dma_rd_sync against frame alignment in RUN and pulses sync_error.
module cn0363_dma_desequencer #(
    parameter int NUM_CHANNELS = 14,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                               clk,
    input  logic                               reset,
    output logic                               dma_rd_en,
    input  logic                               dma_rd_valid,
    input  logic [DATA_WIDTH-1:0]              dma_rd_data,
    input  logic                               dma_rd_sync,
    input  logic                               dma_rd_underflow,
    input  logic                               dma_rd_xfer_req,
    input  logic [NUM_CHANNELS-1:0]            channel_enable,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0] m_data,
    output logic [NUM_CHANNELS-1:0]            m_valid,
    input  logic [NUM_CHANNELS-1:0]            m_ready,
    output logic                               underflow,
    output logic                               sync_error,
    output logic                               processing_reset
);
    localparam int SW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    typedef enum logic [1:0] {IDLE, SYNC, RUN} state_t;

    state_t                  state;
    logic [SW-1:0]           slot;
    logic [NUM_CHANNELS-1:0] mask;
    logic                    outstanding;
    logic [SW-1:0]           first_en;
    logic [SW-1:0]           target;
    logic [SW:0]             nxt;
    logic                    sync_bad;

    function automatic logic [SW-1:0] first_set(input logic [NUM_CHANNELS-1:0] m);
        first_set = '0;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--)
            if (m[i]) first_set = SW'(i);
    endfunction

    // {found, index} of the lowest enabled slot strictly above cur
    function automatic logic [SW:0] next_set(input logic [NUM_CHANNELS-1:0] m, input logic [SW-1:0] cur);
        next_set = '0;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--)
            if (m[i] && (SW'(i) > cur)) next_set = {1'b1, SW'(i)};
    endfunction

    assign processing_reset = reset | ~dma_rd_xfer_req;
    assign first_en = first_set(channel_enable);

`ifdef CN0363_DESEQ_SYNC_CHECK_EN
    logic [SW-1:0] first_mask;
    assign first_mask = first_set(mask);
`endif

    always_comb begin
        sync_bad = 1'b0;
        if (state == SYNC) begin
            target = first_en;
            nxt    = next_set(channel_enable, first_en);
        end else begin
            target = slot;
`ifdef CN0363_DESEQ_SYNC_CHECK_EN
            if (dma_rd_sync && (slot != first_mask)) begin
                target   = first_mask;
                sync_bad = 1'b1;
            end else if (!dma_rd_sync && (slot == first_mask)) begin
                sync_bad = 1'b1;
            end
`endif
            nxt = next_set(mask, target);
        end
    end

    // Only one request in flight; in RUN wait until the target buffer can take the word.
    always_comb begin
        dma_rd_en = 1'b0;
        if (!reset && dma_rd_xfer_req) begin
            if (state == SYNC)
                dma_rd_en = 1'b1;
            else if (state == RUN)
                dma_rd_en = !outstanding && (!m_valid[slot] || m_ready[slot]);
        end
    end

    always_ff @(posedge clk) begin
        sync_error <= 1'b0;
        underflow  <= dma_rd_underflow;
        m_valid    <= m_valid & ~m_ready;
        if (dma_rd_en)
            outstanding <= 1'b1;
        else if (dma_rd_valid)
            outstanding <= 1'b0;

        if (reset) begin
            state       <= IDLE;
            slot        <= '0;
            mask        <= '0;
            outstanding <= 1'b0;
            m_valid     <= '0;
            m_data      <= '0;
            underflow   <= 1'b0;
            sync_error  <= 1'b0;
        end else if (!dma_rd_xfer_req) begin
            state       <= IDLE;
            slot        <= '0;
            outstanding <= 1'b0;
            m_valid     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (channel_enable != '0)
                        state <= SYNC;
                end
                SYNC: begin
                    if (channel_enable == '0) begin
                        state <= IDLE;
                    end else if (dma_rd_valid && outstanding && dma_rd_sync) begin
                        m_data[target*DATA_WIDTH +: DATA_WIDTH] <= dma_rd_data;
                        m_valid[target] <= 1'b1;
                        mask  <= channel_enable;
                        state <= RUN;
                        slot  <= nxt[SW] ? nxt[SW-1:0] : first_en;
                    end
                end
                RUN: begin
                    if (dma_rd_valid && outstanding) begin
                        m_data[target*DATA_WIDTH +: DATA_WIDTH] <= dma_rd_data;
                        m_valid[target] <= 1'b1;
                        sync_error <= sync_bad;
                        if (nxt[SW]) begin
                            slot <= nxt[SW-1:0];
                        end else begin
                            mask <= channel_enable;
                            slot <= first_en;
                            if (channel_enable == '0)
                                state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cn0363_dma_desequencer.sv
// tb/tb_cn0363_dma_desequencer.sv - table-driven bench for cn0363_dma_desequencer.
module tb_cn0363_dma_desequencer;
    localparam int NC = 14;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            dma_rd_en;
    logic            dma_rd_valid = 1'b0;
    logic [DW-1:0]   dma_rd_data = '0;
    logic            dma_rd_sync = 1'b0;
    logic            dma_rd_underflow = 1'b0;
    logic            dma_rd_xfer_req = 1'b0;
    logic [NC-1:0]   channel_enable = '0;
    logic [NC*DW-1:0] m_data;
    logic [NC-1:0]   m_valid;
    logic [NC-1:0]   m_ready = '0;
    logic            underflow;
    logic            sync_error;
    logic            processing_reset;

    cn0363_dma_desequencer #(.NUM_CHANNELS(NC), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset), .dma_rd_en(dma_rd_en), .dma_rd_valid(dma_rd_valid),
        .dma_rd_data(dma_rd_data), .dma_rd_sync(dma_rd_sync), .dma_rd_underflow(dma_rd_underflow),
        .dma_rd_xfer_req(dma_rd_xfer_req), .channel_enable(channel_enable), .m_data(m_data),
        .m_valid(m_valid), .m_ready(m_ready), .underflow(underflow), .sync_error(sync_error),
        .processing_reset(processing_reset)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int serr_cnt = 0;
    logic req_s = 1'b0;
    logic [32:0] dma_q[$];
    int log_slot[$];
    logic [31:0] log_data[$];

    // DMA read port model: answers a request seen in one cycle with a word in the next
    always @(negedge clk) req_s = dma_rd_en;
    always @(posedge clk) begin
        #1;
        if (req_s && dma_q.size() != 0) begin
            {dma_rd_sync, dma_rd_data} = dma_q.pop_front();
            dma_rd_valid = 1'b1;
        end else begin
            dma_rd_valid = 1'b0;
            dma_rd_sync  = 1'b0;
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < NC; k++)
            if (m_valid[k] && m_ready[k]) begin
                log_slot.push_back(k);
                log_data.push_back(m_data[k*DW +: DW]);
            end
        if (sync_error) serr_cnt++;
    end

    typedef struct {
        logic [13:0]      mask;
        int               nwords;
        logic [15:0]      sync_bits;
        int               nexp;
        logic [15:0][3:0] exp_slot;
        logic [15:0][3:0] exp_idx;
    } scen_t;

    scen_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic flush();
        dma_rd_xfer_req = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        dma_q.delete();
        log_slot.delete();
        log_data.delete();
        serr_cnt = 0;
    endtask

    task automatic load(input int n, input logic [15:0] sb, input int base);
        for (int i = 0; i < n; i++) dma_q.push_back({sb[i], 32'(base + i)});
    endtask

    task automatic wait_log(input int n, input string name);
        int c = 0;
        while (log_slot.size() < n && c < 300) begin
            @(negedge clk);
            c++;
        end
        repeat (10) @(negedge clk);
        chk(name, 32'(log_slot.size()), 32'(n));
    endtask

    function automatic logic [31:0] lslot(input int j);
        return (j < log_slot.size()) ? 32'(log_slot[j]) : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] ldata(input int j);
        return (j < log_data.size()) ? log_data[j] : 32'hFFFF_FFFF;
    endfunction

    task automatic expect_seq(input string name, input int n, input logic [15:0][3:0] sl, input int base,
                              input logic [15:0][3:0] ix);
        for (int j = 0; j < n; j++) begin
            chk($sformatf("%s_slot%0d", name, j), lslot(j), 32'(sl[j]));
            chk($sformatf("%s_data%0d", name, j), ldata(j), 32'(base + int'(ix[j])));
        end
    endtask

    initial begin
        int c;
        int en_cnt;
        tbl[0] = '{14'h3FFF, 14, 16'h0001, 14, 64'h00DC_BA98_7654_3210, 64'h00DC_BA98_7654_3210};
        tbl[1] = '{14'h0005, 4, 16'h0001, 4, 64'h2020, 64'h3210};
        tbl[2] = '{14'h0006, 4, 16'h0004, 2, 64'h21, 64'h32};
        tbl[3] = '{14'h0001, 3, 16'h0001, 3, 64'h000, 64'h210};
        tbl[4] = '{14'h2010, 4, 16'h0001, 4, 64'hD4D4, 64'h3210};
        tbl[5] = '{14'h0120, 4, 16'h0002, 3, 64'h585, 64'h321};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_m_valid", 32'(m_valid), 32'h0);
        chk("rst_m_data_zero", 32'(m_data == '0), 32'h1);
        chk("rst_rd_en", 32'(dma_rd_en), 32'h0);
        chk("rst_underflow", 32'(underflow), 32'h0);
        chk("rst_sync_error", 32'(sync_error), 32'h0);
        chk("rst_proc_reset", 32'(processing_reset), 32'h1);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // all-zero mask keeps the block idle
        dma_rd_xfer_req = 1'b1;
        channel_enable  = '0;
        en_cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (dma_rd_en) en_cnt++;
        end
        chk("mask0_no_request", 32'(en_cnt), 32'h0);
        chk("proc_reset_low", 32'(processing_reset), 32'h0);

        for (int i = 0; i < 6; i++) begin
            flush();
            channel_enable = tbl[i].mask;
            m_ready = '1;
            load(tbl[i].nwords, tbl[i].sync_bits, i * 256);
            dma_rd_xfer_req = 1'b1;
            wait_log(tbl[i].nexp, $sformatf("scen%0d_count", i));
            expect_seq($sformatf("scen%0d", i), tbl[i].nexp, tbl[i].exp_slot, i * 256, tbl[i].exp_idx);
        end

        // slot1 back-pressure: requests stall, held word stays put
        flush();
        channel_enable = 14'h0003;
        m_ready = 14'h0001;
        load(6, 16'h0001, 32'h900);
        dma_rd_xfer_req = 1'b1;
        c = 0;
        while (!m_valid[1] && c < 100) begin
            @(negedge clk);
            c++;
        end
        repeat (4) @(negedge clk);
        en_cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (dma_rd_en) en_cnt++;
            if (!m_valid[1] || m_data[DW +: DW] !== 32'h901) en_cnt += 100;
        end
        chk("stall_no_request_hold", 32'(en_cnt), 32'h0);
        m_ready = '1;
        c = 0;
        while (!dma_rd_en && c < 2) begin
            @(negedge clk);
            c++;
        end
        chk("stall_resume", 32'(dma_rd_en), 32'h1);
        wait_log(6, "stall_count");
        expect_seq("stall", 6, 64'h10_1100, 32'h900, 64'h54_3120);

        // frame alignment check
        flush();
        channel_enable = 14'h000F;
        m_ready = '1;
        load(5, 16'h0005, 32'hA00);
        dma_rd_xfer_req = 1'b1;
        wait_log(5, "sync_count");
`ifdef CN0363_DESEQ_SYNC_CHECK_EN
        expect_seq("sync", 5, 64'h2_1010, 32'hA00, 64'h4_3210);
        chk("sync_error_pulses", 32'(serr_cnt), 32'h1);
`else
        expect_seq("sync", 5, 64'h0_3210, 32'hA00, 64'h4_3210);
        chk("sync_error_pulses", 32'(serr_cnt), 32'h0);
`endif

        // xfer_req drop mid-frame then realign
        flush();
        channel_enable = 14'h3FFF;
        m_ready = '0;
        load(14, 16'h0001, 32'h700);
        dma_rd_xfer_req = 1'b1;
        c = 0;
        while (!m_valid[5] && c < 100) begin
            @(negedge clk);
            c++;
        end
        chk("slot5_pending", 32'(m_valid[5]), 32'h1);
        @(posedge clk);
        #1;
        dma_rd_xfer_req = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("drop_m_valid", 32'(m_valid), 32'h0);
        chk("drop_rd_en", 32'(dma_rd_en), 32'h0);
        dma_q.delete();
        log_slot.delete();
        log_data.delete();
        m_ready = '1;
        load(3, 16'h0001, 32'h800);
        @(posedge clk);
        #1;
        dma_rd_xfer_req = 1'b1;
        wait_log(3, "realign_count");
        expect_seq("realign", 3, 64'h210, 32'h800, 64'h210);

        // underflow is a one-cycle delayed copy
        @(posedge clk);
        #1;
        dma_rd_underflow = 1'b1;
        @(negedge clk);
        chk("underflow_before", 32'(underflow), 32'h0);
        @(negedge clk);
        chk("underflow_after", 32'(underflow), 32'h1);
        dma_rd_underflow = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("underflow_clear", 32'(underflow), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
